// File: rtl/seq1010_frame_tx.sv
// Serial frame transmitter: preamble, payload MSB-first, optional even parity, then a zero gap.
// The whole frame is preloaded into one shift register so d_out is simply its registered MSB.
module seq1010_frame_tx #(
    parameter int               DATA_W    = 8,
    parameter int               PRE_W     = 4,
    parameter logic [PRE_W-1:0] PREAMBLE  = 4'b1010,
    parameter int               PARITY_EN = 1,
    parameter int               GAP_CYC   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              d_out,
    output logic              tx_active,
    output logic              frame_done,
    output logic [2:0]        present
);

    localparam int PAR_BITS = (PARITY_EN != 0) ? 1 : 0;
    localparam int FRAME_W  = PRE_W + DATA_W + PAR_BITS;
    localparam int MAX_A    = (PRE_W > DATA_W) ? PRE_W : DATA_W;
    localparam int MAX_B    = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
    localparam int MAX_C    = (MAX_B > 1) ? MAX_B : 1;
    localparam int CNT_W    = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_W - 1);
    localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_PRE  = 3'b001,
        ST_DATA = 3'b010,
        ST_PAR  = 3'b011,
        ST_GAP  = 3'b100
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [FRAME_W-1:0] shift_reg, shift_next;
    logic [FRAME_W-1:0] frame_load;
    logic               tx_active_reg, tx_active_next;
    logic               din_ready_reg, din_ready_next;
    logic               frame_done_reg, frame_done_next;

    // Parity is computed from din on the accept edge, i.e. from the latched word.
    generate
        if (PARITY_EN != 0) begin : g_par
            assign frame_load = {PREAMBLE, din, ^din};
        end else begin : g_nopar
            assign frame_load = {PREAMBLE, din};
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg << 1;
        case (state_reg)
            ST_IDLE: begin
                if (din_valid) begin
                    state_next = ST_PRE;
                    cnt_next   = PRE_LOAD;
                    shift_next = frame_load;
                end
            end
            ST_PRE: begin
                if (cnt_reg == CNT_ZERO) begin
                    state_next = ST_DATA;
                    cnt_next   = DATA_LOAD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_reg != CNT_ZERO) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (PARITY_EN != 0) begin
                    state_next = ST_PAR;
                    cnt_next   = CNT_ZERO;
                end else if (GAP_CYC > 0) begin
                    state_next = ST_GAP;
                    cnt_next   = GAP_LOAD;
                end else begin
                    state_next = ST_IDLE;
                    cnt_next   = CNT_ZERO;
                end
            end
            ST_PAR: begin
                if (GAP_CYC > 0) begin
                    state_next = ST_GAP;
                    cnt_next   = GAP_LOAD;
                end else begin
                    state_next = ST_IDLE;
                    cnt_next   = CNT_ZERO;
                end
            end
            ST_GAP: begin
                if (cnt_reg == CNT_ZERO) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = CNT_ZERO;
                shift_next = '0;
            end
        endcase

        // Flags are derived from the next state so they line up with it after the edge.
        tx_active_next  = state_next inside {ST_PRE, ST_DATA, ST_PAR};
        din_ready_next  = (state_next == ST_IDLE);
        frame_done_next = (state_next == ST_IDLE) && (state_reg inside {ST_DATA, ST_PAR, ST_GAP});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            shift_reg      <= '0;
            tx_active_reg  <= 1'b0;
            din_ready_reg  <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            shift_reg      <= shift_next;
            tx_active_reg  <= tx_active_next;
            din_ready_reg  <= din_ready_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign d_out      = shift_reg[FRAME_W-1];
    assign tx_active  = tx_active_reg;
    assign din_ready  = din_ready_reg;
    assign frame_done = frame_done_reg;
    assign present    = state_reg;

endmodule
